// File: rtl/jtag_l2_pkg.sv
// Shared types and widths for the JTAG L2 burst engine.
// Contents: operation and FSM state enums, the packed burst command, the bus
// widths used by every block, and an address-alignment helper.
package jtag_l2_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_FILL  = 2'b10,
        OP_CHECK = 2'b11
    } jtag_l2_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } jtag_l2_state_e;

    typedef struct packed {
        jtag_l2_op_e        op;
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [DATA_W-1:0]  seed;
    } jtag_l2_cmd_t;

    // Clear the sub-word byte offset so every beat is naturally aligned.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(BE_W - 1);
    endfunction

endpackage

// File: rtl/jtag_l2_burst_engine_rdata_fifo.sv
// Fall-through read-data FIFO between the L2 response port and the TAP stream.
// Ports: i_clk/i_rst (async, active high); i_push/i_data write side;
// i_pop consumes the head when o_valid; o_data is the head word (0 when empty);
// o_count is the current fill level.
module jtag_l2_rdata_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_push,
    input  logic [DATA_W-1:0]                 i_data,
    input  logic                              i_pop,
    output logic                              o_valid,
    output logic [DATA_W-1:0]                 o_data,
    output logic [$clog2(DEPTH+1)-1:0]        o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_pop;
    logic              w_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop   = i_pop && (r_cnt != '0);
    // A push into a full FIFO is only accepted when the head leaves the same cycle.
    assign w_push  = i_push && ((r_cnt != CNT_W'(DEPTH)) || w_pop);
    assign o_valid = (r_cnt != '0);
    assign o_data  = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_cnt;

    // Storage, pointers and fill level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ptr_inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/jtag_l2_burst_engine.sv
// System-clock L2 burst engine behind the debug TAP.
// Runs one WRITE / READ / FILL / CHECK burst at a time on a req/gnt/rvalid port.
// Ports: cmd_* command handshake (ready only in IDLE); wdata_* WRITE stream in;
// rdata_* READ stream out; mem_* L2 port; busy_o/done_o status; err_cnt_o CHECK
// mismatch count (saturating, cleared on accept). Reset rst_i is async, active high.
module jtag_l2_burst_engine
    import jtag_l2_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned PAT_INC   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [DATA_W-1:0] cmd_seed_i,
    input  logic              wdata_valid_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              wdata_ready_o,
    output logic              rdata_valid_o,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              rdata_ready_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [BE_W-1:0]   mem_be_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LEN_W:0]    err_cnt_o
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);

    jtag_l2_state_e    r_state;
    jtag_l2_state_e    w_state_nxt;
    jtag_l2_op_e       r_op;
    jtag_l2_cmd_t      w_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_pat;
    logic [LEN_W-1:0]  r_beats;
    logic [OUT_W-1:0]  r_outst;
    logic [LEN_W:0]    r_err;
    logic [OUT_W-1:0]  w_fifo_cnt;
    logic              w_can_issue;
    logic              w_fire;
    logic              w_rd_fire;
    logic              w_rv;
    logic              w_accept;

    assign w_cmd = '{op: jtag_l2_op_e'(cmd_op_i), addr: cmd_addr_i,
                     len: cmd_len_i, seed: cmd_seed_i};

    assign w_accept      = (r_state == ST_IDLE) && cmd_valid_i;
    assign w_fire        = mem_req_o && mem_gnt_i;
    assign w_rd_fire     = w_fire && ((r_op == OP_READ) || (r_op == OP_CHECK));
    // Responses outside an active burst, or with nothing outstanding, are stale.
    assign w_rv          = mem_rvalid_i && (r_outst != '0) &&
                           ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
    assign wdata_ready_o = w_fire && (r_op == OP_WRITE);
    assign mem_addr_o    = r_addr;
    assign mem_be_o      = '1;
    assign err_cnt_o     = r_err;

    // Issue gating; READ also reserves FIFO room so no response is ever dropped.
    always_comb begin
        w_can_issue = 1'b0;
        case (r_op)
            OP_WRITE: w_can_issue = wdata_valid_i;
            OP_READ:  w_can_issue = ({1'b0, r_outst} + {1'b0, w_fifo_cnt})
                                    < (OUT_W + 1)'(MAX_OUTST);
            OP_FILL:  w_can_issue = 1'b1;
            OP_CHECK: w_can_issue = r_outst < OUT_W'(MAX_OUTST);
            default:  w_can_issue = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and request-side outputs.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req_o   = w_can_issue;
                mem_we_o    = w_can_issue && ((r_op == OP_WRITE) || (r_op == OP_FILL));
                mem_wdata_o = (r_op == OP_WRITE) ? wdata_i :
                              (r_op == OP_FILL)  ? r_pat   : '0;
                if (w_can_issue && mem_gnt_i && (r_beats == '0)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((r_outst == '0) && (w_fifo_cnt == '0)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Command latch, address/pattern/beat counters, outstanding count, CHECK errors.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op    <= OP_WRITE;
            r_addr  <= '0;
            r_pat   <= '0;
            r_beats <= '0;
            r_outst <= '0;
            r_err   <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= w_cmd.op;
                r_addr  <= align_addr(w_cmd.addr);
                r_pat   <= w_cmd.seed;
                r_beats <= w_cmd.len;
                r_err   <= '0;
            end else begin
                if (w_fire) begin
                    r_addr  <= r_addr + ADDR_W'(BE_W);
                    r_beats <= r_beats - LEN_W'(1);
                end
                if (w_fire && (r_op == OP_FILL)) begin
                    r_pat <= r_pat + DATA_W'(PAT_INC);
                end
                if (w_rv && (r_op == OP_CHECK)) begin
                    r_pat <= r_pat + DATA_W'(PAT_INC);
                    if ((mem_rdata_i != r_pat) && (r_err != '1)) begin
                        r_err <= r_err + (LEN_W + 1)'(1);
                    end
                end
            end
            case ({w_rd_fire, w_rv})
                2'b10:   r_outst <= r_outst + OUT_W'(1);
                2'b01:   r_outst <= r_outst - OUT_W'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

    jtag_l2_rdata_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_OUTST)
    ) u_rdata_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_rv && (r_op == OP_READ)),
        .i_data  (mem_rdata_i),
        .i_pop   (rdata_ready_i),
        .o_valid (rdata_valid_o),
        .o_data  (rdata_o),
        .o_count (w_fifo_cnt)
    );

endmodule

// File: tb/tb_jtag_l2_burst_engine.sv
// Directed bench for jtag_l2_burst_engine with a behavioural L2 memory model.
module tb_jtag_l2_burst_engine;
    import jtag_l2_pkg::*;

    localparam int unsigned MAXO = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [1:0]        cmd_op_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [LEN_W-1:0]  cmd_len_i;
    logic [DATA_W-1:0] cmd_seed_i;
    logic              wdata_valid_i;
    logic [DATA_W-1:0] wdata_i;
    logic              wdata_ready_o;
    logic              rdata_valid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              rdata_ready_i;
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [BE_W-1:0]   mem_be_o;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              busy_o;
    logic              done_o;
    logic [LEN_W:0]    err_cnt_o;

    jtag_l2_burst_engine #(.MAX_OUTST(MAXO), .PAT_INC(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_seed_i(cmd_seed_i),
        .wdata_valid_i(wdata_valid_i), .wdata_i(wdata_i), .wdata_ready_o(wdata_ready_o),
        .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o), .rdata_ready_i(rdata_ready_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int due; logic [31:0] data; } rsp_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem_m [logic [31:0]];
    rsp_t        rsp_q [$];
    logic [31:0] wq [$];
    logic [31:0] exp_rd [$];
    logic [31:0] wa_q [$];
    logic [31:0] wd_q [$];
    jtag_l2_op_e cur_op = OP_WRITE;
    int          cyc = 0, rv_lat = 2, gnt_rand = 0, rdy_low = 0, stale_inj = 0;
    int          outst_m = 0, max_outst = 0, done_cnt = 0, done_cyc = 0, rd_cnt = 0;
    int          first_gnt_cyc = -1, last_gnt_cyc = 0, accept_cyc = 0;
    bit          prev_done = 1'b0, rv_now = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : 32'h0;
    endfunction

    // Drive L2 responses and stream inputs for the coming cycle.
    task automatic drive();
        mem_gnt_i = (gnt_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        rv_now    = 1'b0;
        if (stale_inj > 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hDEAD_0000 + 32'(stale_inj);
            stale_inj--;
        end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rsp_q[0].data;
            void'(rsp_q.pop_front());
            rv_now = 1'b1;
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h0;
        end
        wdata_valid_i = (wq.size() > 0);
        wdata_i       = (wq.size() > 0) ? wq[0] : 32'h0;
        rdata_ready_i = (rdy_low == 0);
        if (rdy_low > 0) rdy_low--;
    endtask

    // Observe the cycle just before the rising edge and update the memory model.
    task automatic sample();
        if (mem_req_o && mem_gnt_i) begin
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
            last_gnt_cyc = cyc;
            chk("mem_be", 64'(mem_be_o), 64'hF);
            if (mem_we_o) begin
                mem_m[mem_addr_o] = mem_wdata_o;
                wa_q.push_back(mem_addr_o);
                wd_q.push_back(mem_wdata_o);
                if (cur_op == OP_WRITE) begin
                    chk("wdata_ready", 64'(wdata_ready_o), 64'h1);
                    void'(wq.pop_front());
                end
            end else begin
                rsp_q.push_back('{cyc + rv_lat, mem_rd(mem_addr_o)});
                outst_m++;
            end
        end
        if (rv_now) outst_m--;
        if (outst_m > max_outst) max_outst = outst_m;
        if (rdata_valid_o && rdata_ready_i) begin
            rd_cnt++;
            if (exp_rd.size() > 0) chk("rd_data", 64'(rdata_o), 64'(exp_rd.pop_front()));
            else                   chk("rd_extra", 64'(rdata_valid_o), 64'h0);
        end
        if (prev_done) chk("busy_after_done", 64'(busy_o), 64'h0);
        prev_done = done_o;
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic tick();
        drive();
        #7;
        sample();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic run_cmd(input jtag_l2_op_e op, input logic [31:0] addr,
                           input logic [7:0] len, input logic [31:0] seed);
        int n;
        cur_op        = op;
        done_cnt      = 0;
        first_gnt_cyc = -1;
        max_outst     = 0;
        rd_cnt        = 0;
        wa_q.delete();
        wd_q.delete();
        chk("cmd_ready_idle", 64'(cmd_ready_o), 64'h1);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        cmd_seed_i  = seed;
        accept_cyc  = cyc;
        tick();
        cmd_valid_i = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 4000) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(done_cnt != 0), 64'h1);
        tick();
        chk("done_once", 64'(done_cnt), 64'h1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        rst_i = 1'b1;
        cmd_valid_i = 1'b0; cmd_op_i = 2'b00; cmd_addr_i = '0; cmd_len_i = '0; cmd_seed_i = '0;
        wdata_valid_i = 1'b0; wdata_i = '0; rdata_ready_i = 1'b1;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'h1);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_done", 64'(done_o), 64'h0);
        chk("rst_req", 64'(mem_req_o), 64'h0);
        chk("rst_rvalid", 64'(rdata_valid_o), 64'h0);
        chk("rst_err", 64'(err_cnt_o), 64'h0);
        chk("rst_wready", 64'(wdata_ready_o), 64'h0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // 4-beat WRITE with grant always high.
        wq = '{32'hABBAABBA, 32'hABBAABBB, 32'hABBAABBC, 32'hABBAABBD};
        run_cmd(OP_WRITE, 32'h0, 8'd3, 32'h0);
        chk("wr_count", 64'(wa_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            chk("wr_addr", 64'(wa_q[i]), 64'(32'(4 * i)));
            chk("wr_data", 64'(wd_q[i]), 64'(32'hABBAABBA + 32'(i)));
        end
        chk("wr_done_lat", 64'(done_cyc - last_gnt_cyc), 64'd2);

        // Single-beat WRITE: request the cycle after accept, done two cycles after gnt.
        wq = '{32'h1234_5678};
        run_cmd(OP_WRITE, 32'h40, 8'd0, 32'h0);
        chk("wr1_first_req", 64'(first_gnt_cyc - accept_cyc), 64'd1);
        chk("wr1_done_lat", 64'(done_cyc - last_gnt_cyc), 64'd2);
        chk("wr1_mem", 64'(mem_rd(32'h40)), 64'h1234_5678);

        // READ back with the output stream stalled for 10 cycles.
        exp_rd  = '{32'hABBAABBA, 32'hABBAABBB, 32'hABBAABBC, 32'hABBAABBD};
        rdy_low = 10;
        run_cmd(OP_READ, 32'h0, 8'd3, 32'h0);
        chk("rd_count", 64'(rd_cnt), 64'd4);
        chk("rd_left", 64'(exp_rd.size()), 64'd0);
        chk("rd_max_outst", 64'(max_outst <= int'(MAXO)), 64'h1);

        // FILL 256 beats with random grants.
        gnt_rand = 1;
        run_cmd(OP_FILL, 32'h100, 8'd255, 32'h1000);
        chk("fill_count", 64'(wa_q.size()), 64'd256);
        for (int i = 0; i < 256 && i < wa_q.size(); i++) begin
            chk("fill_addr", 64'(wa_q[i]), 64'(32'h100 + 32'(4 * i)));
            chk("fill_data", 64'(wd_q[i]), 64'(32'h1000 + 32'(i)));
        end

        // CHECK the clean range, then with two corrupted words.
        run_cmd(OP_CHECK, 32'h100, 8'd255, 32'h1000);
        chk("chk_clean_err", 64'(err_cnt_o), 64'd0);
        chk("chk_max_outst", 64'(max_outst <= int'(MAXO)), 64'h1);
        mem_m[32'h104] = mem_m[32'h104] ^ 32'h1;
        mem_m[32'h3F0] = 32'h0;
        run_cmd(OP_CHECK, 32'h100, 8'd255, 32'h1000);
        chk("chk_bad_err", 64'(err_cnt_o), 64'd2);

        // FILL across the top of the address space, unaligned start.
        gnt_rand = 0;
        run_cmd(OP_FILL, 32'hFFFF_FFFA, 8'd3, 32'h7);
        chk("wrap_count", 64'(wa_q.size()), 64'd4);
        if (wa_q.size() == 4) begin
            chk("wrap_a0", 64'(wa_q[0]), 64'hFFFF_FFF8);
            chk("wrap_a1", 64'(wa_q[1]), 64'hFFFF_FFFC);
            chk("wrap_a2", 64'(wa_q[2]), 64'h0000_0000);
            chk("wrap_a3", 64'(wa_q[3]), 64'h0000_0004);
            chk("wrap_d3", 64'(wd_q[3]), 64'hA);
        end
        chk("err_cleared", 64'(err_cnt_o), 64'd0);

        // Reset mid-READ with three reads outstanding, then stale responses.
        rv_lat = 10;
        cur_op = OP_READ;
        exp_rd.delete();
        cmd_valid_i = 1'b1; cmd_op_i = OP_READ; cmd_addr_i = 32'h100; cmd_len_i = 8'd7;
        tick();
        cmd_valid_i = 1'b0;
        n = 0;
        while (outst_m < 3 && n < 50) begin
            tick();
            n++;
        end
        chk("pre_rst_outst", 64'(outst_m), 64'd3);
        rst_i = 1'b1;
        #1;
        chk("rst_req_async", 64'(mem_req_o), 64'h0);
        tick();
        rst_i = 1'b0;
        rsp_q.delete();
        outst_m   = 0;
        stale_inj = 3;
        repeat (5) begin
            tick();
            chk("stale_rvalid", 64'(rdata_valid_o), 64'h0);
            chk("stale_ready", 64'(cmd_ready_o), 64'h1);
        end
        chk("stale_err", 64'(err_cnt_o), 64'd0);
        chk("stale_busy", 64'(busy_o), 64'h0);
        chk("stale_req", 64'(mem_req_o), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
